// File: rtl/muldiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_issue_ctrl
//
// Multicycle issue/writeback controller that sits directly upstream of the
// combinational mul/div unit in the EX stage. It latches one decoded
// M-extension request and holds the operands stable for LATENCY cycles, so
// the multiplier/divider path can be constrained as a multicycle path. It
// then registers the result and offers it to writeback. The pipeline is
// stalled for as long as an operation is outstanding.
//
// Optional feature macro: MULDIV_OPCACHE_EN
//   When defined, a one-entry result cache {valid, rs1, rs2, funct3, result}
//   is kept. A request whose operands and funct3 match the cached entry skips
//   the LATENCY wait and goes straight to DONE with the cached result.
//   When undefined, there is no cache storage and every request takes the
//   full LATENCY path.
//
// Parameters
//   XLEN     datapath width
//   LATENCY  cycles operands are held before the result is sampled (>= 1)
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active-high
//   req_valid_i  in   decoded mul/div instruction present
//   req_ready_o  out  controller can accept a request (state == IDLE)
//   rs1_i        in   operand 1
//   rs2_i        in   operand 2
//   funct3_i     in   M-extension funct3 (MUL..REMU)
//   rd_i         in   destination register
//   flush_i      in   kill the in-flight operation (branch/trap)
//   md_in1_o     out  registered operand 1 to the mul/div unit
//   md_in2_o     out  registered operand 2 to the mul/div unit
//   md_funct3_o  out  registered funct3 to the mul/div unit
//   md_result_i  in   combinational result from the mul/div unit
//   stall_o      out  pipeline stall request (state != IDLE)
//   wb_valid_o   out  result valid to writeback (state == DONE)
//   wb_ready_i   in   writeback accepts the result
//   wb_rd_o      out  destination register of the result
//   wb_data_o    out  registered result
//   dbg_state_o  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Request side: req_valid_i / req_ready_o; req_ready_o depends on
// state only, never on req_valid_i. Writeback side: wb_valid_o / wb_ready_i;
// once wb_valid_o is high, wb_data_o and wb_rd_o stay constant until the
// transfer. flush_i overrides both handshakes: nothing transfers on an edge
// where flush_i is high.
// ---------------------------------------------------------------------------
module muldiv_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] md_in1_o,
    output logic [XLEN-1:0] md_in2_o,
    output logic [2:0]      md_funct3_o,
    input  logic [XLEN-1:0] md_result_i,
    output logic            stall_o,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [1:0]      dbg_state_o
);

    localparam int CNT_W = $clog2(LATENCY) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter reload: the BUSY state lasts exactly LATENCY cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_md_in1;
    logic [XLEN-1:0]  r_md_in2;
    logic [2:0]       r_md_funct3;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_wb_data;

    // Event decodes. flush_i masks every one of them, so a flush beats a
    // simultaneous accept, completion capture or writeback transfer.
    logic w_accept;
    logic w_capture;
    logic w_wb_fire;
    logic w_cache_hit;

    assign w_accept  = (r_state == ST_IDLE) && req_valid_i && !flush_i;
    assign w_capture = (r_state == ST_BUSY) && (r_cnt == '0) && !flush_i;
    assign w_wb_fire = (r_state == ST_DONE) && wb_ready_i && !flush_i;

`ifdef MULDIV_OPCACHE_EN
    // One-entry operation cache. Written on every BUSY->DONE capture from
    // the held operands (which are exactly what md_result_i was computed
    // from). Cleared by reset only: a flush does not make the stored
    // result wrong, it just discards the in-flight operation.
    logic            r_c_valid;
    logic [XLEN-1:0] r_c_rs1;
    logic [XLEN-1:0] r_c_rs2;
    logic [2:0]      r_c_funct3;
    logic [XLEN-1:0] r_c_result;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_c_valid  <= 1'b0;
            r_c_rs1    <= '0;
            r_c_rs2    <= '0;
            r_c_funct3 <= '0;
            r_c_result <= '0;
        end else if (w_capture) begin
            r_c_valid  <= 1'b1;
            r_c_rs1    <= r_md_in1;
            r_c_rs2    <= r_md_in2;
            r_c_funct3 <= r_md_funct3;
            r_c_result <= md_result_i;
        end
    end

    // Compared against the incoming request, not the held operands.
    assign w_cache_hit = r_c_valid
                      && (rs1_i == r_c_rs1)
                      && (rs2_i == r_c_rs2)
                      && (funct3_i == r_c_funct3);
`else
    assign w_cache_hit = 1'b0;
`endif

    // Main FSM and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_md_in1    <= '0;
            r_md_in2    <= '0;
            r_md_funct3 <= '0;
            r_rd        <= '0;
            r_wb_data   <= '0;
        end else if (flush_i) begin
            // Kill whatever is in flight. The counter is parked at zero so
            // it never carries a stale value into the next operation.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Operands are always latched, even on a cache hit,
                        // so the mul/div inputs track the last accepted op.
                        r_md_in1    <= rs1_i;
                        r_md_in2    <= rs2_i;
                        r_md_funct3 <= funct3_i;
                        r_rd        <= rd_i;
`ifdef MULDIV_OPCACHE_EN
                        if (w_cache_hit) begin
                            r_wb_data <= r_c_result;
                            r_cnt     <= '0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_BUSY;
                        end
`else
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_BUSY;
`endif
                    end
                end

                ST_BUSY: begin
                    if (w_capture) begin
                        // Sampled after LATENCY full cycles of stable inputs.
                        r_wb_data <= md_result_i;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    if (w_wb_fire) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the state register only.
    assign req_ready_o = (r_state == ST_IDLE);
    assign stall_o     = (r_state != ST_IDLE);
    assign wb_valid_o  = (r_state == ST_DONE);
    assign md_in1_o    = r_md_in1;
    assign md_in2_o    = r_md_in2;
    assign md_funct3_o = r_md_funct3;
    assign wb_rd_o     = r_rd;
    assign wb_data_o   = r_wb_data;
    assign dbg_state_o = r_state;

    // w_cache_hit is only consumed in the cache build; keep it referenced.
    logic w_unused;
    assign w_unused = w_cache_hit;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Testbench for muldiv_issue_ctrl (XLEN=32, LATENCY=4).
// A golden RV32M model drives md_result_i from md_*_o; expected results are
// hand-computed constants.
module tb_muldiv_issue_ctrl;

    localparam int XLEN = 32;
    localparam int LAT  = 4;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic [2:0]      funct3 = '0;
    logic [4:0]      rd = '0;
    logic            flush = 1'b0;
    logic [XLEN-1:0] md_in1;
    logic [XLEN-1:0] md_in2;
    logic [2:0]      md_funct3;
    logic [XLEN-1:0] md_result;
    logic            stall;
    logic            wb_valid;
    logic            wb_ready = 1'b1;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [1:0]      dbg_state;

    muldiv_issue_ctrl #(.XLEN(XLEN), .LATENCY(LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .funct3_i    (funct3),
        .rd_i        (rd),
        .flush_i     (flush),
        .md_in1_o    (md_in1),
        .md_in2_o    (md_in2),
        .md_funct3_o (md_funct3),
        .md_result_i (md_result),
        .stall_o     (stall),
        .wb_valid_o  (wb_valid),
        .wb_ready_i  (wb_ready),
        .wb_rd_o     (wb_rd),
        .wb_data_o   (wb_data),
        .dbg_state_o (dbg_state)
    );

    // ---------------- golden mul/div unit ----------------
    function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (f)
            F_MUL:    begin p = ua * ub; r = p[31:0];  end
            F_MULH:   begin p = sa * sb; r = p[63:32]; end
            F_MULHSU: begin p = sa * ub; r = p[63:32]; end
            F_MULHU:  begin p = ua * ub; r = p[63:32]; end
            F_DIV: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            F_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    always_comb md_result = golden(md_funct3, md_in1, md_in2);

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Issues one request and follows it to DONE. Returns in the first DONE
    // cycle if wb_ready is low, otherwise one cycle after the transfer.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] exp, input int exp_lat);
        int n;
        logic [31:0] e;
        n = 0;
        while (!req_ready && n < 30) begin tick(); n++; end
        chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        exp_q.push_back(exp);
        req_valid = 1'b1; rs1 = a; rs2 = b; funct3 = f; rd = d;
        tick();
        req_valid = 1'b0;
        chk("md_in1_latched", md_in1, a);
        chk("md_funct3_latched", {29'd0, md_funct3}, {29'd0, f});
        n = 1;
        while (!wb_valid && n < 30) begin
            chk("stall_while_busy", {31'd0, stall}, 32'd1);
            tick();
            n++;
        end
        chk("latency_cycles", n, exp_lat);
        chk("wb_valid_done", {31'd0, wb_valid}, 32'd1);
        chk("stall_in_done", {31'd0, stall}, 32'd1);
        e = exp_q.pop_front();
        chk("wb_data", wb_data, e);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, d});
        if (wb_ready) begin
            tick();
            chk("wb_valid_after_fire", {31'd0, wb_valid}, 32'd0);
            chk("req_ready_after_fire", {31'd0, req_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        vecs[0] = '{F_MUL,    32'd7,          32'd6,          5'd5,  32'd42};
        vecs[1] = '{F_MULH,   32'hFFFF_FFFF,  32'd2,          5'd6,  32'hFFFF_FFFF};
        vecs[2] = '{F_MULHU,  32'hFFFF_FFFF,  32'd2,          5'd7,  32'd1};
        vecs[3] = '{F_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd8,  32'hFFFF_FFFF};
        vecs[4] = '{F_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000};
        vecs[5] = '{F_DIVU,   32'd100,        32'd7,          5'd10, 32'd14};
        vecs[6] = '{F_REM,    32'hFFFF_FFF9,  32'd2,          5'd11, 32'hFFFF_FFFF};
        vecs[7] = '{F_REMU,   32'd100,        32'd7,          5'd12, 32'd2};
        vecs[8] = '{F_DIV,    32'd12345,      32'd0,          5'd13, 32'hFFFF_FFFF};
        vecs[9] = '{F_REMU,   32'd5,          32'd0,          5'd31, 32'd5};

        // ---- reset state ----
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_md_in1", md_in1, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ---- table: full-latency operations, writeback always ready ----
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].exp, LAT + 1);
        end

        // ---- DIV overflow with writeback back-pressure ----
        wb_ready = 1'b0;
        do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, LAT + 1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("bp_stall", {31'd0, stall}, 32'd1);
            chk("bp_wb_data", wb_data, 32'h8000_0000);
            if (i < 2) tick();
        end
        wb_ready = 1'b1;
        tick();
        chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_idle_stall", {31'd0, stall}, 32'd0);

        // ---- flush in 2nd BUSY cycle, operands held while busy ----
        req_valid = 1'b1; rs1 = 32'd11; rs2 = 32'd3; funct3 = F_MUL; rd = 5'd4;
        tick();
        req_valid = 1'b0; rs1 = 32'hDEAD_BEEF;
        tick();
        chk("busy_hold_md_in1", md_in1, 32'd11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_wb_valid", {31'd0, wb_valid}, 32'd0);
            tick();
        end
        do_op(F_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd14, 32'd1, LAT + 1);

        // ---- flush beats a simultaneous accept ----
        req_valid = 1'b1; flush = 1'b1; rs1 = 32'd9;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_accept_stall", {31'd0, stall}, 32'd0);

        // ---- flush beats a simultaneous wb handshake in DONE ----
        wb_ready = 1'b0;
        do_op(F_MUL, 32'd2, 32'd2, 5'd15, 32'd4, LAT + 1);
        flush = 1'b1; wb_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_done_req_ready", {31'd0, req_ready}, 32'd1);

        // ---- async reset mid-BUSY ----
        req_valid = 1'b1; rs1 = 32'd21; rs2 = 32'd2; funct3 = F_MUL; rd = 5'd16;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_md_in1", md_in1, 32'd0);
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // ---- request held in DONE is not accepted until IDLE ----
        wb_ready = 1'b0;
        do_op(F_MUL, 32'd7, 32'd6, 5'd1, 32'd42, LAT + 1);
        req_valid = 1'b1; rs1 = 32'd3; rs2 = 32'd3; funct3 = F_MUL; rd = 5'd2;
        chk("done_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("done_no_accept_md_in1", md_in1, 32'd7);
        chk("done_still_valid", {31'd0, wb_valid}, 32'd1);
        wb_ready = 1'b1;
        tick();
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("held_req_accepted_stall", {31'd0, stall}, 32'd1);
        chk("held_req_md_in1", md_in1, 32'd3);
        n = 0;
        while (!wb_valid && n < 30) begin tick(); n++; end
        chk("held_req_wb_data", wb_data, 32'd9);
        chk("held_req_wb_rd", {27'd0, wb_rd}, 32'd2);
        tick();

        // ---- repeated operation ----
        do_op(F_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, LAT + 1);
`ifdef MULDIV_OPCACHE_EN
        do_op(F_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 1);
`else
        do_op(F_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, LAT + 1);
`endif
        do_op(F_REMU, 32'd100, 32'd7, 5'd22, 32'd2, LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
